cache_miss_handler: RTL and testbench

- Miss/eviction engine for the 4-way, 16-set, 32-byte-line cache.
- Consumes the replacement way chosen by the cache's PLRU tracker.
- Writes back a dirty victim over the DFP (downstream memory) interface, fetches the missing line, and installs it into the way's tag/data arrays.
- Sits between the cache hit/lookup logic and the DFP port; it is the allocating side of the replacement decision.

---
 rtl/cache_miss_handler_pkg.sv | 42 ++++
 rtl/cache_miss_handler_perf_counter.sv | 20 ++
 rtl/cache_miss_handler.sv | 170 +++++++++++++++++
 tb/tb_cache_miss_handler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_miss_handler_pkg.sv
// Shared cache types for the 4-way, 16-set, 32-byte-line cache: geometry,
// way encoding, miss engine states and address slicing helpers.
package cache_types;

    localparam int NUM_SETS  = 16;
    localparam int SET_W     = 4;
    localparam int OFFSET_W  = 5;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = ADDR_W - SET_W - OFFSET_W;
    localparam int CNT_W     = 32;

    typedef enum logic [1:0] {
        Way_A = 2'd0,
        Way_B = 2'd1,
        Way_C = 2'd2,
        Way_D = 2'd3
    } way_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        WB      = 3'd2,
        FILL    = 3'd3,
        INSTALL = 3'd4,
        DONE    = 3'd5
    } miss_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: SET_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                     input logic [SET_W-1:0] set);
        return {tag, set, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_miss_handler_perf_counter.sv
// Free-running event counter; wraps modulo 2^W, never saturates.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count one per enabled cycle, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (en) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cache_miss_handler.sv
// Miss/eviction engine: writes back a dirty PLRU victim, refills the line
// over the DFP port and installs it into the victim way.
module cache_miss_handler
    import cache_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic [1:0]           victim_way,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic [TAG_W-1:0]     victim_tag,
    input  logic [LINE_BITS-1:0] victim_data,
    output logic [ADDR_W-1:0]    dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [LINE_BITS-1:0] dfp_wdata,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp,
    output logic                 fill_we,
    output logic [1:0]           fill_way,
    output logic [SET_W-1:0]     fill_set,
    output logic [TAG_W-1:0]     fill_tag,
    output logic [LINE_BITS-1:0] fill_data,
    output logic                 miss_done,
    output logic                 busy,
    output logic [CNT_W-1:0]     miss_count,
    output logic [CNT_W-1:0]     wb_count
);

    miss_state_t          state_r;
    logic [TAG_W-1:0]     tag_r;
    logic [SET_W-1:0]     set_r;
    way_t                 way_r;
    logic                 wb_needed_r;
    logic [TAG_W-1:0]     vtag_r;
    logic [LINE_BITS-1:0] vdata_r;
    logic [LINE_BITS-1:0] line_r;
    logic [ADDR_W-1:0]    dfp_addr_r;
    logic                 dfp_read_r;
    logic                 dfp_write_r;
    logic                 fill_we_r;
    logic                 miss_done_r;
    logic                 busy_r;
    logic                 wb_en_s;
    logic                 miss_en_s;

    // Miss FSM; every output strobe is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tag_r       <= {TAG_W{1'b0}};
            set_r       <= {SET_W{1'b0}};
            way_r       <= Way_A;
            wb_needed_r <= 1'b0;
            vtag_r      <= {TAG_W{1'b0}};
            vdata_r     <= {LINE_BITS{1'b0}};
            line_r      <= {LINE_BITS{1'b0}};
            dfp_addr_r  <= {ADDR_W{1'b0}};
            dfp_read_r  <= 1'b0;
            dfp_write_r <= 1'b0;
            fill_we_r   <= 1'b0;
            miss_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Victim info is frozen here; later PLRU updates must not leak in.
                    if (miss_req) begin
                        state_r     <= CAPTURE;
                        tag_r       <= addr_tag(miss_addr);
                        set_r       <= addr_set(miss_addr);
                        way_r       <= way_t'(victim_way);
                        wb_needed_r <= victim_valid & victim_dirty;
                        vtag_r      <= victim_tag;
                        vdata_r     <= victim_data;
                        busy_r      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (wb_needed_r) begin
                        state_r     <= WB;
                        dfp_write_r <= 1'b1;
                        dfp_addr_r  <= line_addr(vtag_r, set_r);
                    end else begin
                        state_r    <= FILL;
                        dfp_read_r <= 1'b1;
                        dfp_addr_r <= line_addr(tag_r, set_r);
                    end
                end
                WB: begin
                    if (dfp_resp) begin
                        state_r     <= FILL;
                        dfp_write_r <= 1'b0;
                        dfp_read_r  <= 1'b1;
                        dfp_addr_r  <= line_addr(tag_r, set_r);
                    end
                end
                FILL: begin
                    if (dfp_resp) begin
                        state_r    <= INSTALL;
                        dfp_read_r <= 1'b0;
                        line_r     <= dfp_rdata;
                        fill_we_r  <= 1'b1;
                    end
                end
                INSTALL: begin
                    state_r     <= DONE;
                    fill_we_r   <= 1'b0;
                    miss_done_r <= 1'b1;
                end
                DONE: begin
                    state_r     <= IDLE;
                    miss_done_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    dfp_read_r  <= 1'b0;
                    dfp_write_r <= 1'b0;
                    fill_we_r   <= 1'b0;
                    miss_done_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Counter enables: a writeback completes on its response, a refill in DONE.
    always_comb begin
        wb_en_s   = 1'b0;
        miss_en_s = 1'b0;
        if (state_r == WB) begin
            wb_en_s = dfp_resp;
        end else if (state_r == DONE) begin
            miss_en_s = 1'b1;
        end else begin
            wb_en_s   = 1'b0;
            miss_en_s = 1'b0;
        end
    end

    perf_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (miss_en_s),
        .count (miss_count)
    );

    perf_counter #(.W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (wb_en_s),
        .count (wb_count)
    );

    assign dfp_addr  = dfp_addr_r;
    assign dfp_read  = dfp_read_r;
    assign dfp_write = dfp_write_r;
    assign dfp_wdata = vdata_r;
    assign fill_we   = fill_we_r;
    assign fill_way  = way_r;
    assign fill_set  = set_r;
    assign fill_tag  = tag_r;
    assign fill_data = line_r;
    assign miss_done = miss_done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: clean/dirty/invalid victims, PLRU
// changes after acceptance, reset mid-writeback, back-to-back and spurious responses.
module tb_cache_miss_handler;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic [1:0]   victim_way;
    logic         victim_valid;
    logic         victim_dirty;
    logic [22:0]  victim_tag;
    logic [255:0] victim_data;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         fill_we;
    logic [1:0]   fill_way;
    logic [3:0]   fill_set;
    logic [22:0]  fill_tag;
    logic [255:0] fill_data;
    logic         miss_done;
    logic         busy;
    logic [31:0]  miss_count;
    logic [31:0]  wb_count;

    int checks   = 0;
    int failures = 0;
    int fill_cnt = 0;
    int done_cnt = 0;
    int wr_cyc   = 0;
    int snap_fill, snap_done, snap_wr;

    localparam logic [255:0] D_VIC  = {8{32'hA5A5_0F0F}};
    localparam logic [255:0] D_VIC2 = {8{32'h1234_5678}};
    localparam logic [255:0] D_RD1  = {8{32'hCAFE_0001}};
    localparam logic [255:0] D_RD2  = {8{32'hBEEF_0002}};
    localparam logic [255:0] D_RD3  = {8{32'h0DD0_0003}};

    cache_miss_handler dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .dfp_addr     (dfp_addr),
        .dfp_read     (dfp_read),
        .dfp_write    (dfp_write),
        .dfp_wdata    (dfp_wdata),
        .dfp_rdata    (dfp_rdata),
        .dfp_resp     (dfp_resp),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .fill_set     (fill_set),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .miss_done    (miss_done),
        .busy         (busy),
        .miss_count   (miss_count),
        .wb_count     (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_victim(input logic [31:0] a, input logic [1:0] w, input logic v,
                              input logic d, input logic [22:0] t, input logic [255:0] dat);
        miss_addr    = a;
        victim_way   = w;
        victim_valid = v;
        victim_dirty = d;
        victim_tag   = t;
        victim_data  = dat;
    endtask

    // Mid-cycle monitor: read/write exclusion plus strobe bookkeeping.
    always @(negedge clk) begin
        check("rd_wr_exclusive", {255'd0, dfp_read & dfp_write}, 256'd0);
        if (fill_we)   fill_cnt++;
        if (miss_done) done_cnt++;
        if (dfp_write) wr_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        miss_req  = 1'b0;
        dfp_resp  = 1'b0;
        dfp_rdata = 256'd0;
        set_victim(32'h0, 2'd0, 1'b0, 1'b0, 23'h0, 256'd0);
        tick();
        tick();
        check("rst_busy",      {255'd0, busy},      256'd0);
        check("rst_read",      {255'd0, dfp_read},  256'd0);
        check("rst_write",     {255'd0, dfp_write}, 256'd0);
        check("rst_addr",      {224'd0, dfp_addr},  256'd0);
        check("rst_fill_we",   {255'd0, fill_we},   256'd0);
        check("rst_done",      {255'd0, miss_done}, 256'd0);
        check("rst_miss_cnt",  {224'd0, miss_count}, 256'd0);
        check("rst_wb_cnt",    {224'd0, wb_count},  256'd0);
        check("rst_wdata",     dfp_wdata,           256'd0);
        check("rst_fill_data", fill_data,           256'd0);
        rst = 1'b0;
        tick();

        // Clean victim, read latency 3: miss_done must land in cycle 7.
        miss_req = 1'b1;
        set_victim(32'h0000_1A40, 2'd2, 1'b1, 1'b0, 23'h55, D_VIC);
        tick();
        check("c1_busy",  {255'd0, busy},     256'd1);
        check("c1_read",  {255'd0, dfp_read}, 256'd0);
        tick();
        check("c2_read",  {255'd0, dfp_read},  256'd1);
        check("c2_write", {255'd0, dfp_write}, 256'd0);
        check("c2_addr",  {224'd0, dfp_addr},  {224'd0, 32'h0000_1A40});
        tick();
        tick();
        check("c4_read_hold", {255'd0, dfp_read}, 256'd1);
        tick();
        dfp_resp  = 1'b1;
        dfp_rdata = D_RD1;
        tick();
        dfp_resp = 1'b0;
        check("c6_fill_we",  {255'd0, fill_we},   256'd1);
        check("c6_fill_way", {254'd0, fill_way},  256'd2);
        check("c6_fill_set", {252'd0, fill_set},  256'd2);
        check("c6_fill_tag", {233'd0, fill_tag},  256'hD);
        check("c6_fill_dat", fill_data,           D_RD1);
        check("c6_read_off", {255'd0, dfp_read},  256'd0);
        check("c6_done_lo",  {255'd0, miss_done}, 256'd0);
        tick();
        check("c7_done",     {255'd0, miss_done}, 256'd1);
        check("c7_fill_off", {255'd0, fill_we},   256'd0);
        check("c7_busy",     {255'd0, busy},      256'd1);
        tick();
        miss_req = 1'b0;
        check("c8_done_lo",  {255'd0, miss_done},  256'd0);
        check("c8_busy",     {255'd0, busy},       256'd0);
        check("c8_miss_cnt", {224'd0, miss_count}, 256'd1);
        check("c8_wb_cnt",   {224'd0, wb_count},   256'd0);
        check("c8_no_write", 256'(wr_cyc),         256'd0);
        tick();

        // Dirty victim: writeback first, then refill.
        miss_req = 1'b1;
        set_victim(32'h0000_34A0, 2'd1, 1'b1, 1'b1, 23'h7, D_VIC2);
        tick();
        tick();
        check("d2_write", {255'd0, dfp_write}, 256'd1);
        check("d2_read",  {255'd0, dfp_read},  256'd0);
        check("d2_addr",  {224'd0, dfp_addr},  {224'd0, 32'h0000_0EA0});
        check("d2_wdata", dfp_wdata,           D_VIC2);
        tick();
        check("d3_write_hold", {255'd0, dfp_write}, 256'd1);
        check("d3_addr_hold",  {224'd0, dfp_addr},  {224'd0, 32'h0000_0EA0});
        dfp_resp = 1'b1;
        tick();
        dfp_resp = 1'b0;
        check("d4_write_off", {255'd0, dfp_write}, 256'd0);
        check("d4_read",      {255'd0, dfp_read},  256'd1);
        check("d4_addr",      {224'd0, dfp_addr},  {224'd0, 32'h0000_34A0});
        check("d4_wb_cnt",    {224'd0, wb_count},  256'd1);
        tick();
        dfp_resp  = 1'b1;
        dfp_rdata = D_RD2;
        tick();
        dfp_resp = 1'b0;
        check("d6_fill_we",  {255'd0, fill_we},  256'd1);
        check("d6_fill_way", {254'd0, fill_way}, 256'd1);
        check("d6_fill_set", {252'd0, fill_set}, 256'd5);
        check("d6_fill_tag", {233'd0, fill_tag}, 256'h1A);
        check("d6_fill_dat", fill_data,          D_RD2);
        tick();
        check("d7_done", {255'd0, miss_done}, 256'd1);
        tick();
        miss_req = 1'b0;
        check("d8_miss_cnt", {224'd0, miss_count}, 256'd2);
        tick();

        // Victim inputs change after acceptance: captured decision must hold.
        snap_wr  = wr_cyc;
        miss_req = 1'b1;
        set_victim(32'h0000_5C60, 2'd2, 1'b1, 1'b0, 23'h11, D_VIC);
        tick();
        set_victim(32'h0000_5C60, 2'd0, 1'b1, 1'b1, 23'h1FF, D_VIC2);
        tick();
        check("p2_write", {255'd0, dfp_write}, 256'd0);
        check("p2_read",  {255'd0, dfp_read},  256'd1);
        check("p2_addr",  {224'd0, dfp_addr},  {224'd0, 32'h0000_5C60});
        dfp_resp  = 1'b1;
        dfp_rdata = D_RD3;
        tick();
        dfp_resp = 1'b0;
        check("p3_fill_we",  {255'd0, fill_we},  256'd1);
        check("p3_fill_way", {254'd0, fill_way}, 256'd2);
        check("p3_fill_set", {252'd0, fill_set}, 256'd3);
        check("p3_fill_tag", {233'd0, fill_tag}, 256'h2E);
        tick();
        check("p4_done", {255'd0, miss_done}, 256'd1);
        tick();
        miss_req = 1'b0;
        check("p5_wb_cnt",   {224'd0, wb_count},   256'd1);
        check("p5_miss_cnt", {224'd0, miss_count}, 256'd3);
        check("p5_no_write", 256'(wr_cyc),         256'(snap_wr));
        tick();

        // Reset while writing back: abort with no install or completion.
        miss_req = 1'b1;
        set_victim(32'h0000_34A0, 2'd3, 1'b1, 1'b1, 23'h7, D_VIC2);
        tick();
        tick();
        check("r2_write", {255'd0, dfp_write}, 256'd1);
        snap_fill = fill_cnt;
        snap_done = done_cnt;
        rst      = 1'b1;
        miss_req = 1'b0;
        tick();
        rst = 1'b0;
        check("r3_write_off", {255'd0, dfp_write},  256'd0);
        check("r3_read_off",  {255'd0, dfp_read},   256'd0);
        check("r3_busy",      {255'd0, busy},       256'd0);
        check("r3_miss_cnt",  {224'd0, miss_count}, 256'd0);
        check("r3_wb_cnt",    {224'd0, wb_count},   256'd0);
        tick();
        tick();
        tick();
        check("r6_no_fill", 256'(fill_cnt), 256'(snap_fill));
        check("r6_no_done", 256'(done_cnt), 256'(snap_done));
        check("r6_busy",    {255'd0, busy}, 256'd0);

        // Back-to-back: invalid victim miss, then a dirty one accepted right after DONE.
        snap_fill = fill_cnt;
        miss_req  = 1'b1;
        set_victim(32'h0000_1A40, 2'd3, 1'b0, 1'b1, 23'h3C, D_VIC);
        tick();
        tick();
        check("b2_read",  {255'd0, dfp_read},  256'd1);
        check("b2_write", {255'd0, dfp_write}, 256'd0);
        dfp_resp  = 1'b1;
        dfp_rdata = D_RD1;
        tick();
        dfp_resp = 1'b0;
        check("b3_fill_way", {254'd0, fill_way}, 256'd3);
        tick();
        check("b4_done", {255'd0, miss_done}, 256'd1);
        tick();
        set_victim(32'h0000_34A0, 2'd1, 1'b1, 1'b1, 23'h7, D_VIC2);
        check("b5_idle",     {255'd0, busy},       256'd0);
        check("b5_miss_cnt", {224'd0, miss_count}, 256'd1);
        tick();
        check("b6_busy", {255'd0, busy}, 256'd1);
        tick();
        check("b7_write", {255'd0, dfp_write}, 256'd1);
        check("b7_addr",  {224'd0, dfp_addr},  {224'd0, 32'h0000_0EA0});
        dfp_resp = 1'b1;
        tick();
        check("b8_read", {255'd0, dfp_read}, 256'd1);
        dfp_rdata = D_RD2;
        tick();
        dfp_resp = 1'b0;
        check("b9_fill_way", {254'd0, fill_way}, 256'd1);
        check("b9_fill_dat", fill_data,          D_RD2);
        tick();
        check("b10_done", {255'd0, miss_done}, 256'd1);
        tick();
        miss_req = 1'b0;
        check("b11_miss_cnt", {224'd0, miss_count}, 256'd2);
        check("b11_wb_cnt",   {224'd0, wb_count},   256'd1);
        check("b11_fills",    256'(fill_cnt - snap_fill), 256'd2);

        // Spurious response in IDLE must be ignored.
        tick();
        dfp_resp = 1'b1;
        tick();
        dfp_resp = 1'b0;
        check("s_busy",    {255'd0, busy},      256'd0);
        check("s_read",    {255'd0, dfp_read},  256'd0);
        check("s_fill_we", {255'd0, fill_we},   256'd0);
        tick();
        check("s_miss_cnt", {224'd0, miss_count}, 256'd2);
        check("s_wb_cnt",   {224'd0, wb_count},   256'd1);
        check("s_done_lo",  {255'd0, miss_done},  256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
